sha512_compress: RTL and testbench
==================================

# sha512_compress

SHA-512 compression engine serving the chunk-hash handshake used by the HMAC and PBKDF2 sequencers. It takes one pre-padded 1024-bit block and an 8-word input state, runs the 80 FIPS 180-4 rounds at one round per clock, and presents the 512-bit chained output state. Each operation is started by releasing the block's reset, and `done` stays asserted with the result held until the next reset. The block is the responder on this handshake. The sequencer drives inputs and sequencing; this block only computes.

## Interface
- No parameters. Round constants K[0..79] are a fixed internal ROM.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low. Low means idle and cleared. Each low→high release starts one compression.
- `done`  out  1  high when `oH` is valid. Held until `reset` goes low.
- `chunk`  in  1024  padded message block, big-endian. W0 = `chunk[1023:960]`, W15 = `chunk[63:0]`.
- `iH`  in  8×64 (`[0:7][63:0]`)  input state. `iH[0]` is a.
- `oH`  out  8×64 (`[0:7][63:0]`)  output state, `oH[i] = iH[i] + final_var[i]` mod 2^64.

## Operation
- States: IDLE → LOAD → ROUND → FINAL → DONE.
- Reset low (asynchronous):
  - state = IDLE, round counter = 0, `done` = 0, `oH` = 0.
  - Working vars a..h and the schedule window are don't-care.
- IDLE: leaves to LOAD on the first rising edge with reset high.
- LOAD (1 edge):
  - a..h ← `iH[0..7]`.
  - Copy of `iH` ← `iH`. This copy is used for the final add.
  - Window W[0..15] ← the 16 words of `chunk`.
  - t ← 0.
  - `chunk` and `iH` are sampled only here. They may change afterwards.
- ROUND (80 edges, t = 0..79):
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[0]. T2 = Σ0(a) + Maj(a,b,c).
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Window shifts down one word: W[i] ← W[i+1].
  - New W[15] = σ1(W[14]) + W[9] + σ0(W[1]) + W[0].
  - t increments. After t=79 the next state is FINAL.
- All additions are 64-bit modulo 2^64, with no carry out.
  - Σ0 = ROTR28^ROTR34^ROTR39. Σ1 = ROTR14^ROTR18^ROTR41.
  - σ0 = ROTR1^ROTR8^SHR7. σ1 = ROTR19^ROTR61^SHR6.
- FINAL (1 edge): `oH[i]` ← iH copy[i] + var[i], then go to DONE.
- DONE:
  - `done` = 1.
  - `oH` and `done` are held for as long as reset stays high.
  - Input changes are ignored.
- Reset mid-operation, in any state: immediate return to IDLE with `done` = 0 and `oH` = 0. No partial result is ever flagged valid.
- The block never restarts on its own. A new compression requires a reset low pulse of at least one `clk` period, then release.

## Timing
- Reset is released asynchronously. The driver releases it from a `clk`-registered source, so release meets recovery time.
- Count the edges from the first rising edge with reset high:
  - edge 1 = LOAD
  - edges 2–81 = rounds 0–79
  - edge 82 = FINAL
- `done` and the valid `oH` are visible after edge 82, with no combinational path from inputs.
- The sequencer may sample `oH` on the same edge at which it drives reset low. `oH` clears only after reset has actually gone low.
- Throughput: one block per 83 cycles minimum, counting one reset-low cycle.

## Test plan
- **Empty message.**
  - Stimulus: `chunk` = 0x80 followed by 127 zero bytes; `iH` = FIPS H0; release reset.
  - Required: `oH` = cf83e135…f927da3e (full SHA-512("") digest); `done` rises exactly after edge 82.
- **"abc".**
  - Stimulus: `chunk` = 616263 80 00…00 with length 0x18 in the last byte; `iH` = H0.
  - Required: `oH` = ddaf35a193617aba…a54ca49f.
- **Two-block chaining (FIPS 896-bit "abcdefgh…nopqrstu").**
  - Stimulus: block 1 with H0, then a reset pulse; block 2 with `iH` = previous `oH`, captured on the same edge that drives reset low.
  - Required: final `oH` = 8e959b75…874be909.
- **Mid-operation reset.**
  - Stimulus: drop reset at round 40, then release with new inputs ("abc").
  - Required: `done`/`oH` go to 0 asynchronously with no clock; the second run gives the "abc" digest with the edge-82 latency.
- **Hold.**
  - Stimulus: after `done`, keep reset high for 1000 cycles while randomizing `chunk`/`iH`.
  - Required: `done` = 1 and `oH` unchanged throughout.
- **Input sampling.**
  - Stimulus: change `chunk`/`iH` to garbage on the edge after LOAD.
  - Required: result still equals the digest of the values present at LOAD.

Source files
------------

// File: rtl/sha512_compress.sv
// SHA-512 compression engine: one 1024-bit block, 80 rounds at one round per clock.
// Each release of the active-low reset starts one compression; the result is held until the next reset.
module sha512_compress (
    input  logic               clk,
    input  logic               reset,
    input  logic [1023:0]      chunk,
    input  logic [0:7][63:0]   iH,
    output logic               done,
    output logic [0:7][63:0]   oH
);

    // The IDLE exit edge is the load edge, so rounds run on edges 2..81 and the final add lands on edge 82.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [0:79][63:0] K = {
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic logic [63:0] big_sigma0(input logic [63:0] x);
        return {x[27:0], x[63:28]} ^ {x[33:0], x[63:34]} ^ {x[38:0], x[63:39]};
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x);
        return {x[13:0], x[63:14]} ^ {x[17:0], x[63:18]} ^ {x[40:0], x[63:41]};
    endfunction

    function automatic logic [63:0] small_sigma0(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] small_sigma1(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    logic [1:0]          state;
    logic [6:0]          round;
    logic [0:7][63:0]    v;
    logic [0:7][63:0]    h_copy;
    logic [0:15][63:0]   w;
    logic [63:0]         t1;
    logic [63:0]         t2;
    logic [63:0]         w_new;

    always_comb begin
        t1    = v[7] + big_sigma1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[round] + w[0];
        t2    = big_sigma0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    // Control and result registers: the only state that reset clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            round <= 7'd0;
            done  <= 1'b0;
            oH    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    round <= 7'd0;
                    state <= ROUND;
                end
                ROUND: begin
                    round <= round + 7'd1;
                    if (round == 7'd79)
                        state <= FINAL;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++)
                        oH[i] <= h_copy[i] + v[i];
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= DONE;
            endcase
        end
    end

    // Datapath carries no reset; its contents only matter between load and the final add.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            v      <= iH;
            h_copy <= iH;
            w      <= chunk;
        end else if (state == ROUND) begin
            v <= {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
            w <= {w[1:15], w_new};
        end
    end

endmodule

// File: tb/tb_sha512_compress.sv
// Directed bench for sha512_compress using FIPS 180-4 known-answer digests.
// Covers reset state, latency, hold, async clear, mid-run reset, input sampling and chaining.
module tb_sha512_compress;

    logic               clk;
    logic               reset;
    logic [1023:0]      chunk;
    logic [0:7][63:0]   iH;
    logic               done;
    logic [0:7][63:0]   oH;

    int checks;
    int failures;

    localparam logic [511:0] H0 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [511:0] DIGEST_EMPTY = {
        64'hcf83e1357eefb8bd, 64'hf1542850d66d8007, 64'hd620e4050b5715dc, 64'h83f4a921d36ce9ce,
        64'h47d0d13c5d85f2b0, 64'hff8318d2877eec2f, 64'h63b931bd47417a81, 64'ha538327af927da3e};
    localparam logic [511:0] DIGEST_ABC = {
        64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
    localparam logic [511:0] DIGEST_TWO = {
        64'h8e959b75dae313da, 64'h8cf4f72814fc143f, 64'h8f7779c6eb9f7fa1, 64'h7299aeadb6889018,
        64'h501d289e4900f7e4, 64'h331b99dec4b5433a, 64'hc7d329eeb6dd2654, 64'h5e96e55b874be909};

    localparam logic [1023:0] BLOCK_EMPTY = {8'h80, 1016'h0};
    localparam logic [1023:0] BLOCK_ABC   = {24'h616263, 8'h80, 864'h0, 128'h18};
    localparam logic [1023:0] BLOCK_TWO_B = 1024'h380;

    sha512_compress dut (
        .clk   (clk),
        .reset (reset),
        .chunk (chunk),
        .iH    (iH),
        .done  (done),
        .oH    (oH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 32; i++)
            chunk[i*32 +: 32] = $urandom();
        for (int i = 0; i < 8; i++)
            iH[i] = {$urandom(), $urandom()};
    endtask

    // Releases reset at a falling edge so the next rising edge is edge 1 (load); optionally scrambles inputs after it.
    task automatic apply_stimulus(input logic [1023:0] c, input logic [511:0] h, input bit scramble);
        @(negedge clk);
        chunk = c;
        iH    = h;
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (scramble)
            randomize_inputs();
    endtask

    task automatic finish_block(input string tag, input logic [511:0] expected);
        repeat (80) @(posedge clk);
        #1;
        check_output({tag, "_done_edge81"}, {511'd0, done}, 512'd0);
        @(posedge clk);
        #1;
        check_output({tag, "_done_edge82"}, {511'd0, done}, 512'd1);
        check_output({tag, "_digest"}, oH, expected);
    endtask

    task automatic async_clear(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output({tag, "_done_cleared"}, {511'd0, done}, 512'd0);
        check_output({tag, "_oH_cleared"}, oH, 512'd0);
    endtask

    initial begin
        logic [895:0]  msg;
        logic [511:0]  held;
        logic [511:0]  saved;

        checks   = 0;
        failures = 0;
        msg      = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
        reset    = 1'b0;
        chunk    = '0;
        iH       = '0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_done", {511'd0, done}, 512'd0);
        check_output("reset_oH", oH, 512'd0);

        $display("[TB] empty message block");
        apply_stimulus(BLOCK_EMPTY, H0, 1'b0);
        finish_block("empty", DIGEST_EMPTY);

        $display("[TB] hold for 1000 cycles with random inputs");
        held = oH;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            randomize_inputs();
            if (i % 100 == 0) begin
                check_output("hold_done", {511'd0, done}, 512'd1);
                check_output("hold_oH", oH, DIGEST_EMPTY);
            end
        end
        check_output("hold_oH_stable", oH, held);
        async_clear("after_done");

        $display("[TB] abc block with inputs scrambled after load");
        apply_stimulus(BLOCK_ABC, H0, 1'b1);
        finish_block("abc_scrambled", DIGEST_ABC);

        $display("[TB] two-block chaining");
        async_clear("pre_chain");
        apply_stimulus({msg, 8'h80, 120'h0}, H0, 1'b0);
        repeat (81) @(posedge clk);
        #1;
        check_output("chain_blk1_done", {511'd0, done}, 512'd1);
        @(posedge clk);
        saved = oH;
        reset = 1'b0;
        #1;
        check_output("chain_oH_cleared", oH, 512'd0);
        @(posedge clk);
        apply_stimulus(BLOCK_TWO_B, saved, 1'b0);
        finish_block("chain_blk2", DIGEST_TWO);

        $display("[TB] reset at round 40 then abc");
        async_clear("pre_midrun");
        apply_stimulus(BLOCK_EMPTY, H0, 1'b0);
        repeat (40) @(posedge clk);
        async_clear("midrun");
        @(posedge clk);
        #1;
        check_output("midrun_held_low", {511'd0, done}, 512'd0);
        apply_stimulus(BLOCK_ABC, H0, 1'b0);
        finish_block("abc_after_abort", DIGEST_ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
